multi_blink_timer: RTL
======================

Name: multi_blink_timer

Overview:
- Multi-channel, mode-selectable successor to the single-channel toggle timer used by the board LED/blink designs.
- Each of NUM_CH channels has its own period, duty and mode, and produces a registered output plus a one-cycle period tick.
- Supported modes are free-running toggle, PWM and one-shot pulse.
- Sits between the switch/register front-end and the LED/GPIO pins.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 32, width of period/duty values and per-channel counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  NUM_CH  per-channel enable (level; bit i drives channel i).
- i_mode  input  2*NUM_CH  per-channel mode, channel i at [2i+1:2i].
- i_period  input  CNT_W*NUM_CH  per-channel period in clk cycles, channel i at [CNT_W*i +: CNT_W].
- i_duty  input  CNT_W*NUM_CH  per-channel PWM high time in cycles, same packing.
- i_sync  input  1  one-cycle pulse; phase-aligns all enabled channels.
- o_out  output  NUM_CH  registered channel outputs.
- o_tick  output  NUM_CH  one-cycle pulse at period end (wrap or one-shot completion).

Behaviour:
- Reset (async, reset_n=0): every cnt=0, o_out=0, o_tick=0, one-shot state=IDLE, stored mode=0. All outputs are registered; no combinational input-to-output path.
- Effective period: P = (i_period==0) ? 1 : i_period. Compares use cnt >= P-1, so lowering the period mid-count wraps on the next cycle with no overrun.
- Per-channel priority per clock edge: en low > i_sync > mode change > mode operation.
- en low: cnt<=0, o_out<=0, o_tick<=0, state<=IDLE.
- i_sync with en high: cnt<=0, o_out<=0, o_tick<=0, state<=IDLE. A one-shot channel re-fires on the next cycle.
- Mode change: mode differs from the registered mode_q while en is high. Same clear as i_sync; mode_q<=i_mode.
- Mode 0, TOGGLE:
  - If cnt >= P-1: cnt<=0, o_out<=~o_out, o_tick<=1.
  - Else: cnt<=cnt+1, o_tick<=0.
  - o_out half-period = P cycles. P=1 toggles every cycle.
- Mode 1, PWM:
  - cnt wraps as in TOGGLE, with o_tick<=1 on wrap.
  - o_out <= (cnt < i_duty), evaluated on the current cnt, so o_out lags cnt by one cycle.
  - i_duty=0 gives constant 0; i_duty >= P gives constant 1.
  - A duty change takes effect on the next cycle.
- Mode 2, ONESHOT, states IDLE/RUN/DONE:
  - IDLE (en high): o_out<=1, cnt<=0, go to RUN.
  - RUN: if cnt >= P-1, then o_out<=0, o_tick<=1, go to DONE; else cnt<=cnt+1.
  - o_out is high for exactly P cycles.
  - DONE: hold o_out=0 and cnt; leave only via en low, i_sync or mode change.
- Mode 3: reserved. Behaves as en low: o_out=0, cnt=0.
- o_tick is high for exactly one cycle per event and is 0 in every other cycle.
- Counter arithmetic is CNT_W bits unsigned. The counter never exceeds P-1, so it cannot wrap.
- Channels are fully independent except for the shared i_sync.

Decomposition:
- Package blink_pkg:
  - Mode localparams MODE_TOGGLE=2'd0, MODE_PWM=2'd1, MODE_ONESHOT=2'd2, MODE_RSVD=2'd3.
  - One-shot state encoding OS_IDLE, OS_RUN, OS_DONE.
- Sub-module blink_channel:
  - Holds one counter, mode_q, state and the output registers.
  - Ports: clk, reset_n, en, mode, period, duty, sync, out, tick.
- multi_blink_timer only unpacks the buses and instantiates NUM_CH blink_channel instances in a generate loop.

Test Plan:
- TOGGLE, P=5, en=1 from cycle 0 -> o_out toggles every 5 cycles; o_tick high one cycle at each toggle; en=0 mid-count -> o_out=0, cnt=0 next cycle.
- PWM, P=10, D=3 -> o_out pattern 3 high / 7 low, repeating with period 10; D=0 -> o_out constant 0; D=12 -> o_out constant 1; o_tick every 10 cycles.
- ONESHOT, P=4 -> o_out high exactly 4 cycles, then o_tick pulse, then o_out stays 0 in DONE; i_sync pulse -> o_out high again for 4 cycles.
- Period edge cases:
  - P=0 in TOGGLE -> behaves as P=1, toggling every cycle.
  - Period lowered from 100 to 3 while cnt=50 -> wrap on the next cycle, then period 3.
- Mode change TOGGLE->PWM mid-count on channel 1 while channels 0 and 2 run TOGGLE -> channel 1 clears cnt and o_out in that cycle; channels 0 and 2 are unaffected.
- Assert reset_n mid-operation, asynchronously between edges -> all o_out and o_tick go to 0 immediately; release -> channels restart from cnt=0.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared definitions for the multi-channel blink timer.
// Holds the channel mode codes and the one-shot state encoding.
package blink_pkg;

    localparam logic [1:0] MODE_TOGGLE  = 2'd0;
    localparam logic [1:0] MODE_PWM     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    typedef enum logic [1:0] {
        OS_IDLE = 2'd0,
        OS_RUN  = 2'd1,
        OS_DONE = 2'd2
    } os_state_t;

endpackage

// File: rtl/blink_channel.sv
// One blink timer channel: toggle, PWM or one-shot, with a period tick.
// Ports: clk, reset_n (async low), en, mode, period, duty, sync -> out, tick.
module blink_channel
    import blink_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic             sync,
    output logic             out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic [1:0]       mode_q;
    os_state_t        state;
    logic             wrap;
    logic             clear;

    // A period of zero is treated as one cycle.
    assign last  = (period == '0) ? '0 : period - CNT_W'(1);
    // ">=" rather than "==" so a shrunken period wraps at once.
    assign wrap  = (cnt >= last);
    // Reserved mode parks the channel exactly like a disabled one.
    assign clear = !en || sync || (mode != mode_q) || (mode == MODE_RSVD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            out    <= 1'b0;
            tick   <= 1'b0;
            state  <= OS_IDLE;
            mode_q <= MODE_TOGGLE;
        end else if (clear) begin
            cnt   <= '0;
            out   <= 1'b0;
            tick  <= 1'b0;
            state <= OS_IDLE;
            // Only a genuine mode change (not en low or sync) latches it.
            if (en && !sync) begin
                mode_q <= mode;
            end
        end else begin
            unique case (mode)
                MODE_TOGGLE: begin
                    if (wrap) begin
                        cnt  <= '0;
                        out  <= ~out;
                        tick <= 1'b1;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        tick <= 1'b0;
                    end
                end
                MODE_PWM: begin
                    out <= (cnt < duty);
                    if (wrap) begin
                        cnt  <= '0;
                        tick <= 1'b1;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        tick <= 1'b0;
                    end
                end
                MODE_ONESHOT: begin
                    unique case (state)
                        OS_IDLE: begin
                            out   <= 1'b1;
                            cnt   <= '0;
                            tick  <= 1'b0;
                            state <= OS_RUN;
                        end
                        OS_RUN: begin
                            if (wrap) begin
                                out   <= 1'b0;
                                tick  <= 1'b1;
                                state <= OS_DONE;
                            end else begin
                                cnt  <= cnt + CNT_W'(1);
                                tick <= 1'b0;
                            end
                        end
                        default: begin
                            out  <= 1'b0;
                            tick <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    cnt   <= '0;
                    out   <= 1'b0;
                    tick  <= 1'b0;
                    state <= OS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_blink_timer.sv
// Multi-channel blink timer: NUM_CH independent channels sharing one sync.
// Ports: clk, reset_n, en, i_mode, i_period, i_duty, i_sync -> o_out, o_tick.
module multi_blink_timer
    import blink_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [2*NUM_CH-1:0]     i_mode,
    input  logic [CNT_W*NUM_CH-1:0] i_period,
    input  logic [CNT_W*NUM_CH-1:0] i_duty,
    input  logic                    i_sync,
    output logic [NUM_CH-1:0]       o_out,
    output logic [NUM_CH-1:0]       o_tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        blink_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (en[i]),
            .mode   (i_mode[2*i +: 2]),
            .period (i_period[CNT_W*i +: CNT_W]),
            .duty   (i_duty[CNT_W*i +: CNT_W]),
            .sync   (i_sync),
            .out    (o_out[i]),
            .tick   (o_tick[i])
        );
    end

endmodule
